matrix_tile_feeder: RTL and testbench

- Upstream stage of the tile multipliers.
- Arbitrates the per-PE load requests `req_in[]` and `req_w[]` from NUM_PE multiplier instances, round-robin.
- Streams exactly BURST words from an input-operand source (A) or a weight source (B) into the winning PE's local RAM.
- Drives that PE's `grant_in`/`grant_w` as a per-word write strobe, with the data broadcast on shared buses.
- A and B channels are independent and run concurrently.

---
 rtl/feeder_pkg.sv | 29 ++
 rtl/feeder_channel.sv | 116 +++++++++++
 rtl/matrix_tile_feeder.sv | 89 ++++++++
 tb/tb_matrix_tile_feeder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types and the round-robin pick used by both feeder channels.
package feeder_pkg;

   typedef enum logic {IDLE, XFER} feeder_state_t;

   localparam int unsigned MAX_PE   = 32;
   localparam int unsigned MAX_PE_W = $clog2(MAX_PE);

   // Index of the first set request at or above ptr, wrapping modulo num_pe.
   function automatic int unsigned rr_pick(input logic [MAX_PE-1:0] req,
                                           input int unsigned       ptr,
                                           input int unsigned       num_pe);
      int unsigned idx;
      logic        found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int unsigned o = 0; o < MAX_PE; o++) begin
         if (!found && (o < num_pe)) begin
            idx = ptr + o;
            if (idx >= num_pe) idx = idx - num_pe;
            if (req[idx[MAX_PE_W-1:0]]) begin
               rr_pick = idx;
               found   = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/feeder_channel.sv
// One tile-load channel: RR arbiter, burst FSM and registered grant/data outputs.
// Optional stall counter when MATRIX_FEEDER_STALL_EN is defined.
module feeder_channel
   import feeder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int NUM_PE = 4,
   parameter int BURST  = 16
`ifdef MATRIX_FEEDER_STALL_EN
   ,
   parameter int STALL_W = 16
`endif
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_PE-1:0] req,
   output logic [NUM_PE-1:0] grant,
   output logic [WIDTH-1:0]  data,
   input  logic              src_valid,
   input  logic [WIDTH-1:0]  src_data,
   output logic              src_ready,
   output logic              busy,
   output logic              last
`ifdef MATRIX_FEEDER_STALL_EN
   ,
   output logic [STALL_W-1:0] stall_cnt
`endif
);

   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   feeder_state_t     state_reg, state_next;
   logic [PW-1:0]     owner_reg, owner_next;
   logic [PW-1:0]     ptr_reg, ptr_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic [NUM_PE-1:0] grant_reg;
   logic [NUM_PE-1:0] owner_oh;
   logic [WIDTH-1:0]  data_reg;
   logic              last_reg;
   logic              accept;
   logic              final_word;

   for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_owner_oh
      assign owner_oh[gi] = (owner_reg == PW'(gi));
   end

   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      ptr_next   = ptr_reg;
      cnt_next   = cnt_reg;
      src_ready  = (state_reg == XFER);
      accept     = src_valid & src_ready;
      final_word = accept && (cnt_reg == CW'(BURST - 1));
      case (state_reg)
         IDLE: begin
            if (|req) begin
               owner_next = PW'(rr_pick(MAX_PE'(req), 32'(ptr_reg), NUM_PE));
               cnt_next   = '0;
               state_next = XFER;
            end
         end
         XFER: begin
            if (final_word) begin
               state_next = IDLE;
               ptr_next   = (owner_reg == PW'(NUM_PE - 1)) ? '0 : owner_reg + 1'b1;
            end else if (accept) begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         owner_reg <= '0;
         ptr_reg   <= '0;
         cnt_reg   <= '0;
         grant_reg <= '0;
         data_reg  <= '0;
         last_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         ptr_reg   <= ptr_next;
         cnt_reg   <= cnt_next;
         // Outputs lag the accept by one cycle; data holds between grants.
         grant_reg <= accept ? owner_oh : '0;
         if (accept) data_reg <= src_data;
         last_reg  <= final_word;
      end
   end

`ifdef MATRIX_FEEDER_STALL_EN
   logic [STALL_W-1:0] stall_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else if ((state_reg == XFER) && !src_valid && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`endif

   assign grant = grant_reg;
   assign data  = data_reg;
   assign last  = last_reg;
   assign busy  = (state_reg == XFER);

endmodule

// File: rtl/matrix_tile_feeder.sv
// Feeds A (input operand) and B (weight) tiles into PE RAMs via two independent channels.
// Define MATRIX_FEEDER_STALL_EN to add per-channel stall counters.
module matrix_tile_feeder
   import feeder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int NUM_PE = 4,
   parameter int BURST  = 16
`ifdef MATRIX_FEEDER_STALL_EN
   ,
   parameter int STALL_W = 16
`endif
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_PE-1:0] req_in,
   input  logic [NUM_PE-1:0] req_w,
   output logic [NUM_PE-1:0] grant_in,
   output logic [NUM_PE-1:0] grant_w,
   output logic [WIDTH-1:0]  data_a,
   output logic [WIDTH-1:0]  data_b,
   input  logic              src_a_valid,
   input  logic [WIDTH-1:0]  src_a_data,
   output logic              src_a_ready,
   input  logic              src_b_valid,
   input  logic [WIDTH-1:0]  src_b_data,
   output logic              src_b_ready,
   output logic              busy_a,
   output logic              busy_b,
   output logic              last_a,
   output logic              last_b
`ifdef MATRIX_FEEDER_STALL_EN
   ,
   output logic [STALL_W-1:0] stall_cnt_a,
   output logic [STALL_W-1:0] stall_cnt_b
`endif
);

   feeder_channel #(
      .WIDTH   (WIDTH),
      .NUM_PE  (NUM_PE),
      .BURST   (BURST)
`ifdef MATRIX_FEEDER_STALL_EN
      ,
      .STALL_W (STALL_W)
`endif
   ) u_chan_a (
      .clk       (clk),
      .rst       (rst),
      .req       (req_in),
      .grant     (grant_in),
      .data      (data_a),
      .src_valid (src_a_valid),
      .src_data  (src_a_data),
      .src_ready (src_a_ready),
      .busy      (busy_a),
      .last      (last_a)
`ifdef MATRIX_FEEDER_STALL_EN
      ,
      .stall_cnt (stall_cnt_a)
`endif
   );

   feeder_channel #(
      .WIDTH   (WIDTH),
      .NUM_PE  (NUM_PE),
      .BURST   (BURST)
`ifdef MATRIX_FEEDER_STALL_EN
      ,
      .STALL_W (STALL_W)
`endif
   ) u_chan_b (
      .clk       (clk),
      .rst       (rst),
      .req       (req_w),
      .grant     (grant_w),
      .data      (data_b),
      .src_valid (src_b_valid),
      .src_data  (src_b_data),
      .src_ready (src_b_ready),
      .busy      (busy_b),
      .last      (last_b)
`ifdef MATRIX_FEEDER_STALL_EN
      ,
      .stall_cnt (stall_cnt_b)
`endif
   );

endmodule

// File: tb/tb_matrix_tile_feeder.sv
// Directed bench for matrix_tile_feeder (default NUM_PE=4, BURST=16, WIDTH=16).
module tb_matrix_tile_feeder;

   localparam int NREC = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req_in = '0, req_w = '0;
   logic [3:0]  grant_in, grant_w;
   logic [15:0] data_a, data_b;
   logic        src_a_valid = 1'b0, src_b_valid = 1'b0;
   logic [15:0] src_a_data = '0, src_b_data = '0;
   logic        src_a_ready, src_b_ready, busy_a, busy_b, last_a, last_b;
`ifdef MATRIX_FEEDER_STALL_EN
   logic [15:0] stall_cnt_a, stall_cnt_b;
`endif

   matrix_tile_feeder dut (
      .clk(clk), .rst(rst), .req_in(req_in), .req_w(req_w),
      .grant_in(grant_in), .grant_w(grant_w), .data_a(data_a), .data_b(data_b),
      .src_a_valid(src_a_valid), .src_a_data(src_a_data), .src_a_ready(src_a_ready),
      .src_b_valid(src_b_valid), .src_b_data(src_b_data), .src_b_ready(src_b_ready),
      .busy_a(busy_a), .busy_b(busy_b), .last_a(last_a), .last_b(last_b)
`ifdef MATRIX_FEEDER_STALL_EN
      , .stall_cnt_a(stall_cnt_a), .stall_cnt_b(stall_cnt_b)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Per-cycle record: outputs seen at negedge, plus whether the coming edge accepts.
   logic [3:0]  r_gi[NREC], r_gw[NREC];
   logic [15:0] r_da[NREC], r_db[NREC];
   logic        r_la[NREC], r_lb[NREC], r_ra[NREC], r_ba[NREC], r_acca[NREC];
   int          nrec;

   logic [15:0] a_word = 16'h0100, b_word = 16'h8000;
   logic        a_pend = 1'b0, b_pend = 1'b0, a_tog = 1'b1, b_en = 1'b0;
   int          a_mode = 0;
   logic [15:0] acc_a[$], acc_b[$];

   task automatic step();
      @(negedge clk);
      if (a_pend) begin acc_a.push_back(src_a_data); a_word = a_word + 16'd1; end
      if (b_pend) begin acc_b.push_back(src_b_data); b_word = b_word + 16'd1; end
      if (a_mode == 1) begin src_a_valid = a_tog; a_tog = ~a_tog; end
      else src_a_valid = 1'b1;
      src_a_data  = a_word;
      src_b_valid = b_en;
      src_b_data  = b_word;
      a_pend = src_a_valid & src_a_ready;
      b_pend = src_b_valid & src_b_ready;
      if (nrec < NREC) begin
         r_gi[nrec] = grant_in; r_gw[nrec] = grant_w;
         r_da[nrec] = data_a;   r_db[nrec] = data_b;
         r_la[nrec] = last_a;   r_lb[nrec] = last_b;
         r_ra[nrec] = src_a_ready; r_ba[nrec] = busy_a; r_acca[nrec] = a_pend;
         nrec++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req_in = '0; req_w = '0;
      src_a_valid = 1'b0; src_b_valid = 1'b0;
      a_pend = 1'b0; b_pend = 1'b0; a_mode = 0; b_en = 1'b0; a_tog = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      nrec = 0; acc_a.delete(); acc_b.delete();
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({grant_in, grant_w} !== 8'h00) begin failures++; $display("FAIL reset_grants got=%b exp=00000000", {grant_in, grant_w}); end
      checks++; if ({data_a, data_b} !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", {data_a, data_b}); end
      checks++; if ({busy_a, busy_b, last_a, last_b, src_a_ready, src_b_ready} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {busy_a, busy_b, last_a, last_b, src_a_ready, src_b_ready}); end
`ifdef MATRIX_FEEDER_STALL_EN
      checks++; if ({stall_cnt_a, stall_cnt_b} !== 32'h0) begin failures++; $display("FAIL reset_stall got=%h exp=0", {stall_cnt_a, stall_cnt_b}); end
`endif
      rst = 1'b0;
      @(negedge clk);
      checks++; if (src_a_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", src_a_ready); end
      $display("test_reset done");
   endtask

   task automatic test_single_pe();
      int nready, ngr, nbad, first_r, first_g, last_g, nlast, last_idx, ndmis, k;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 0) req_in = 4'b0100;
         if (i == 1) req_in = 4'b0000;
      end
      nready = 0; ngr = 0; nbad = 0; first_r = -1; first_g = -1; last_g = -1;
      nlast = 0; last_idx = -1; ndmis = 0; k = 0;
      for (int i = 0; i < nrec; i++) begin
         if (r_ra[i]) begin nready++; if (first_r < 0) first_r = i; end
         if (r_gi[i] == 4'b0100) begin
            ngr++; if (first_g < 0) first_g = i; last_g = i;
            if (k >= acc_a.size() || r_da[i] !== acc_a[k]) ndmis++;
            k++;
         end else if (r_gi[i] != 4'b0000) nbad++;
         if (r_la[i]) begin nlast++; last_idx = i; end
      end
      checks++; if (first_r !== 1) begin failures++; $display("FAIL single_arb_latency got=%0d exp=1", first_r); end
      checks++; if (nready !== 16) begin failures++; $display("FAIL single_ready_cycles got=%0d exp=16", nready); end
      checks++; if (ngr !== 16) begin failures++; $display("FAIL single_grants got=%0d exp=16", ngr); end
      checks++; if (nbad !== 0) begin failures++; $display("FAIL single_stray_grants got=%0d exp=0", nbad); end
      checks++; if (first_g !== first_r + 1) begin failures++; $display("FAIL single_grant_latency got=%0d exp=%0d", first_g, first_r + 1); end
      checks++; if (last_g - first_g !== 15) begin failures++; $display("FAIL single_contiguous got=%0d exp=15", last_g - first_g); end
      checks++; if (nlast !== 1 || last_idx !== last_g) begin failures++; $display("FAIL single_last got=%0d@%0d exp=1@%0d", nlast, last_idx, last_g); end
      checks++; if (ndmis !== 0) begin failures++; $display("FAIL single_data got=%0d_mismatches exp=0", ndmis); end
      $display("test_single_pe: grants=%0d first=%0d last=%0d", ngr, first_g, last_g);
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_pe[5];
      logic [3:0] run_pe[8];
      int run_start[8], run_len[8];
      int nruns, ndmis, k;
      exp_pe = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
      do_reset();
      for (int i = 0; i < 72; i++) begin
         step();
         if (i == 0) req_in = 4'b1011;
      end
      req_in = 4'b0000;
      for (int i = 0; i < 40 && busy_a; i++) step();
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rr_drain_timeout got=%b exp=0", busy_a); end
      step(); step();
      nruns = 0; ndmis = 0; k = 0;
      for (int i = 0; i < nrec; i++) begin
         if (r_gi[i] != 4'b0000) begin
            if (i == 0 || r_gi[i-1] !== r_gi[i]) begin
               if (nruns < 8) begin run_pe[nruns] = r_gi[i]; run_start[nruns] = i; run_len[nruns] = 0; end
               nruns++;
            end
            if (nruns <= 8) run_len[nruns-1]++;
            if (k >= acc_a.size() || r_da[i] !== acc_a[k]) ndmis++;
            k++;
         end
      end
      checks++; if (nruns !== 5) begin failures++; $display("FAIL rr_burst_count got=%0d exp=5", nruns); end
      for (int r = 0; r < 5 && r < nruns; r++) begin
         $display("burst %0d: pe_mask=%b grants=%0d start=%0d", r, run_pe[r], run_len[r], run_start[r]);
         checks++; if (run_pe[r] !== exp_pe[r]) begin failures++; $display("FAIL rr_owner_%0d got=%b exp=%b", r, run_pe[r], exp_pe[r]); end
         checks++; if (run_len[r] !== 16) begin failures++; $display("FAIL rr_len_%0d got=%0d exp=16", r, run_len[r]); end
         if (r > 0) begin
            checks++;
            if (run_start[r] - (run_start[r-1] + run_len[r-1]) !== 1) begin
               failures++; $display("FAIL rr_gap_%0d got=%0d exp=1", r, run_start[r] - (run_start[r-1] + run_len[r-1]));
            end
         end
      end
      checks++; if (ndmis !== 0) begin failures++; $display("FAIL rr_data got=%0d_mismatches exp=0", ndmis); end
   endtask

   task automatic test_stall();
      int ngr, nbad, nbusy, nacc, nfollow, ndmis, nlast, k;
      do_reset();
      a_mode = 1; a_tog = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 0) req_in = 4'b0001;
         if (i == 1) req_in = 4'b0000;
      end
      ngr = 0; nbad = 0; nbusy = 0; nacc = 0; nfollow = 0; ndmis = 0; nlast = 0; k = 0;
      for (int i = 0; i < nrec; i++) begin
         if (r_ba[i]) nbusy++;
         if (r_acca[i]) nacc++;
         if (r_la[i]) nlast++;
         if (r_gi[i] == 4'b0001) begin
            ngr++;
            if (i == 0 || !r_acca[i-1]) nfollow++;
            if (k >= acc_a.size() || r_da[i] !== acc_a[k]) ndmis++;
            k++;
         end else if (r_gi[i] != 4'b0000) nbad++;
      end
      checks++; if (ngr !== 16) begin failures++; $display("FAIL stall_grants got=%0d exp=16", ngr); end
      checks++; if (nbad !== 0) begin failures++; $display("FAIL stall_stray_grants got=%0d exp=0", nbad); end
      checks++; if (nbusy !== 32) begin failures++; $display("FAIL stall_xfer_cycles got=%0d exp=32", nbusy); end
      checks++; if (nacc !== 16) begin failures++; $display("FAIL stall_accepts got=%0d exp=16", nacc); end
      checks++; if (nfollow !== 0) begin failures++; $display("FAIL stall_grant_without_accept got=%0d exp=0", nfollow); end
      checks++; if (ndmis !== 0) begin failures++; $display("FAIL stall_data got=%0d_mismatches exp=0", ndmis); end
      checks++; if (nlast !== 1) begin failures++; $display("FAIL stall_last got=%0d exp=1", nlast); end
`ifdef MATRIX_FEEDER_STALL_EN
      checks++; if (stall_cnt_a !== 16'd16) begin failures++; $display("FAIL stall_cnt_a got=%0d exp=16", stall_cnt_a); end
      checks++; if (stall_cnt_b !== 16'd0) begin failures++; $display("FAIL stall_cnt_b got=%0d exp=0", stall_cnt_b); end
`endif
      a_mode = 0;
      $display("test_stall: grants=%0d xfer_cycles=%0d", ngr, nbusy);
   endtask

   task automatic test_req_drop();
      int g, ngr, nbad, nlast;
      do_reset();
      g = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (i == 0) req_in = 4'b0010;
         if (r_gi[nrec-1] == 4'b0010) g++;
         if (g == 3) req_in = 4'b0000;
      end
      ngr = 0; nbad = 0; nlast = 0;
      for (int i = 0; i < nrec; i++) begin
         if (r_gi[i] == 4'b0010) ngr++;
         else if (r_gi[i] != 4'b0000) nbad++;
         if (r_la[i]) nlast++;
      end
      checks++; if (ngr !== 16) begin failures++; $display("FAIL drop_grants got=%0d exp=16", ngr); end
      checks++; if (nbad !== 0) begin failures++; $display("FAIL drop_stray_grants got=%0d exp=0", nbad); end
      checks++; if (nlast !== 1) begin failures++; $display("FAIL drop_last got=%0d exp=1", nlast); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", busy_a); end
      $display("test_req_drop: grants=%0d", ngr);
   endtask

   task automatic test_reset_mid_burst();
      int g, ngr, nbad, nlast, last_idx, last_g, first_g;
      logic [3:0] first_pe;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 0) req_in = 4'b0100;
         if (i == 1) req_in = 4'b0000;
      end
      req_in = 4'b1010;
      g = 0; first_pe = 4'b0000;
      for (int i = 0; i < 30 && g < 7; i++) begin
         step();
         if (r_gi[nrec-1] != 4'b0000) begin
            if (g == 0) first_pe = r_gi[nrec-1];
            g++;
         end
      end
      checks++; if (first_pe !== 4'b1000) begin failures++; $display("FAIL rst_pre_owner got=%b exp=1000", first_pe); end
      checks++; if (g !== 7) begin failures++; $display("FAIL rst_pre_timeout got=%0d exp=7", g); end
      #2 rst = 1'b1;
      #1;
      checks++; if (grant_in !== 4'b0000) begin failures++; $display("FAIL rst_async_grant got=%b exp=0000", grant_in); end
      checks++; if ({busy_a, src_a_ready, last_a} !== 3'b000) begin failures++; $display("FAIL rst_async_flags got=%b exp=000", {busy_a, src_a_ready, last_a}); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0; a_pend = 1'b0;
      nrec = 0; acc_a.delete();
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 0) req_in = 4'b0000;
      end
      ngr = 0; nbad = 0; nlast = 0; last_idx = -1; last_g = -1; first_g = -1;
      for (int i = 0; i < nrec; i++) begin
         if (r_gi[i] == 4'b0010) begin ngr++; if (first_g < 0) first_g = i; last_g = i; end
         else if (r_gi[i] != 4'b0000) nbad++;
         if (r_la[i]) begin nlast++; last_idx = i; end
      end
      checks++; if (ngr !== 16) begin failures++; $display("FAIL rst_restart_grants_pe1 got=%0d exp=16", ngr); end
      checks++; if (nbad !== 0) begin failures++; $display("FAIL rst_restart_stray got=%0d exp=0", nbad); end
      checks++; if (nlast !== 1 || last_idx !== last_g) begin failures++; $display("FAIL rst_restart_last got=%0d@%0d exp=1@%0d", nlast, last_idx, last_g); end
      if (first_g >= 0 && acc_a.size() > 0) begin
         checks++; if (r_da[first_g] !== acc_a[0]) begin failures++; $display("FAIL rst_restart_word0 got=%h exp=%h", r_da[first_g], acc_a[0]); end
      end
      $display("test_reset_mid_burst: restart grants=%0d", ngr);
   endtask

   task automatic test_concurrent();
      int na, nb, nbad, dma, dmb, ka, kb, nlb;
      do_reset();
      b_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 0) begin req_in = 4'b0001; req_w = 4'b0001; end
         if (i == 1) begin req_in = 4'b0000; req_w = 4'b0000; end
      end
      na = 0; nb = 0; nbad = 0; dma = 0; dmb = 0; ka = 0; kb = 0; nlb = 0;
      for (int i = 0; i < nrec; i++) begin
         if (r_gi[i] == 4'b0001) begin
            na++; if (ka >= acc_a.size() || r_da[i] !== acc_a[ka]) dma++; ka++;
         end else if (r_gi[i] != 4'b0000) nbad++;
         if (r_gw[i] == 4'b0001) begin
            nb++; if (kb >= acc_b.size() || r_db[i] !== acc_b[kb]) dmb++; kb++;
         end else if (r_gw[i] != 4'b0000) nbad++;
         if (r_lb[i]) nlb++;
      end
      checks++; if (na !== 16) begin failures++; $display("FAIL conc_grant_in got=%0d exp=16", na); end
      checks++; if (nb !== 16) begin failures++; $display("FAIL conc_grant_w got=%0d exp=16", nb); end
      checks++; if (nbad !== 0) begin failures++; $display("FAIL conc_stray got=%0d exp=0", nbad); end
      checks++; if (dma !== 0) begin failures++; $display("FAIL conc_data_a got=%0d_mismatches exp=0", dma); end
      checks++; if (dmb !== 0) begin failures++; $display("FAIL conc_data_b got=%0d_mismatches exp=0", dmb); end
      checks++; if (nlb !== 1) begin failures++; $display("FAIL conc_last_b got=%0d exp=1", nlb); end
      checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL conc_b_idle got=%b exp=0", busy_b); end
      $display("test_concurrent: grant_in=%0d grant_w=%0d", na, nb);
   endtask

   initial begin
      nrec = 0;
      test_reset();
      test_single_pe();
      test_round_robin();
      test_stall();
      test_req_drop();
      test_reset_mid_burst();
      test_concurrent();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
